stream_demux: RTL and testbench
===============================

# stream_demux

Registered 1-to-N stream demultiplexer: routes a valid/ready packet stream from a single source to one of `N_OUT` sinks, selected by `s_sel` on each packet's first beat. The selection is locked for the whole packet, and packets addressed to a non-existent output are dropped and counted. It is the distribution-side counterpart of the team's select-driven multiplexers and sits between a shared producer and per-channel consumers.

## Interface
- `WIDTH`, 8, data width in bits
- `N_OUT`, 4, number of outputs, 2..2^`SEL_W`
- `SEL_W`, 2, width of the select field
- `CNT_W`, 16, width of the drop counter

- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  reset, synchronous, active-high
- `s_data`  in  `WIDTH`  input beat data
- `s_sel`  in  `SEL_W`  destination index, sampled on first beat of packet only
- `s_last`  in  1  marks final beat of packet
- `s_valid`  in  1  input beat valid
- `s_ready`  out  1  input beat accepted when `s_valid && s_ready`
- `m_data`  out  `WIDTH`  output beat data, shared by all outputs
- `m_last`  out  1  output final-beat flag, shared
- `m_valid`  out  `N_OUT`  one-hot per-output valid
- `m_ready`  in  `N_OUT`  per-output ready
- `drop_count`  out  `CNT_W`  number of dropped packets, saturating

## Operation
- Internal output register: `out_valid`, `out_dst`, `out_data`, `out_last`.
  - `m_valid[i] = out_valid && (out_dst == i)`.
  - `m_data = out_data`, `m_last = out_last`.
- Output register drains when `m_ready[out_dst]` is high.
- `s_ready = !out_valid || m_ready[out_dst]` in IDLE and PKT. `s_ready = 1` in DROP.
- FSM states: IDLE (no packet open), PKT (packet open, `dst` latched), DROP (discarding an invalid packet).
- IDLE, accepted beat with `s_sel < N_OUT`:
  - Load output register with `out_dst = s_sel`; latch `dst = s_sel`.
  - If `s_last`, stay IDLE; else go to PKT.
- IDLE, accepted beat with `s_sel >= N_OUT`:
  - Discard the beat; output register is not loaded.
  - `drop_count` increments by 1, saturating at 2^`CNT_W`-1.
  - If `s_last`, stay IDLE; else go to DROP.
- PKT:
  - `s_sel` is ignored.
  - Each accepted beat loads the output register with `out_dst = dst`.
  - Accepted `s_last` returns to IDLE.
- DROP:
  - Every beat is accepted and discarded; the counter does not increment again.
  - Accepted `s_last` returns to IDLE.
- Output register update rules:
  - Load and drain in the same cycle: the new beat replaces the old one, giving full throughput.
  - Drain without load: `out_valid` clears.
- `m_ready` of non-selected outputs has no effect.
- `m_data`/`m_last` hold their last value while `out_valid = 0`.

## Timing
- Latency: a beat accepted at edge k appears on `m_*` from edge k onward (one register stage) and holds until its `m_ready` is seen.
- Throughput: 1 beat/cycle when the destination keeps `m_ready = 1`.
- `s_ready` is combinational from `m_ready` and registered state only; it never depends on `s_valid`.
- Reset values (at the first edge with `rst` = 1):
  - State = IDLE.
  - `out_valid = 0`, so `m_valid = 0`.
  - `out_data = 0`, `out_last = 0`, `out_dst = 0`, `dst = 0`.
  - `drop_count = 0`.
- Reset has priority over all other updates.
- Reset mid-packet abandons the packet; any held beat is lost.
- After reset, the next accepted beat is treated as a first beat.
- Back-to-back packets are supported: a first beat may be accepted in the cycle after an accepted `s_last`, with a new `s_sel`.
- Single-beat packets (`s_last` on the first beat) never leave IDLE.
- `drop_count` saturates and does not wrap; it clears only on reset.

## Test plan
- Reset, then a 3-beat packet with `s_sel`=2, data 0x11/0x22/0x33, all `m_ready`=1.
  - `m_valid`=4'b0100 for 3 consecutive cycles with data 0x11, 0x22, 0x33.
  - `m_last`=1 on 0x33 only; `s_ready` stays 1.
- Change `s_sel` to 0 during the 2nd beat of a packet sent to output 1.
  - All beats appear on `m_valid[1]`.
  - The next packet, sent with `s_sel`=0, appears on `m_valid[0]`.
- Hold `m_ready[3]`=0 for 4 cycles during a packet to output 3.
  - `s_ready`=0 and `m_data` stable for those cycles; no beat is lost or duplicated.
  - Holding `m_ready[0]`=0 at the same time has no effect.
- `N_OUT`=3, 2-beat packet with `s_sel`=3.
  - No `m_valid` asserts; `s_ready`=1 for both beats; `drop_count`=1.
  - A following packet to output 0 is delivered normally.
- `CNT_W`=2, send 5 invalid single-beat packets.
  - `drop_count` reads 1, 2, 3, 3, 3.
- Assert `rst` for 1 cycle mid-packet while a beat is held.
  - `m_valid`=0 and `drop_count`=0 on the next cycle.
  - The next beat, sent with `s_sel`=1, is routed as a first beat to output 1.

Source files
------------

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N valid/ready packet demultiplexer.
// The destination is taken from s_sel on a packet's first beat and locked
// until s_last. Packets whose first-beat s_sel has no matching output are
// consumed without being forwarded, and each one adds 1 to a saturating
// counter.
//
// Ports:
//   clk, rst     - rising-edge clock, synchronous active-high reset
//   s_data       - input beat data
//   s_sel        - destination index, used on a first beat only
//   s_last       - marks the final beat of a packet
//   s_valid      - input beat valid
//   s_ready      - input beat ready
//   m_data       - output beat data, shared by all outputs
//   m_last       - output final-beat flag, shared by all outputs
//   m_valid      - one-hot per-output valid
//   m_ready      - per-output ready
//   drop_count   - saturating count of dropped packets
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int SEL_W = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic [SEL_W-1:0] s_sel,
  input  logic             s_last,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [N_OUT-1:0] m_valid,
  input  logic [N_OUT-1:0] m_ready,
  output logic [CNT_W-1:0] drop_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } state_t;

  // One extra bit so N_OUT == 2**SEL_W is representable.
  localparam logic [SEL_W:0] N_OUT_L = (SEL_W + 1)'(N_OUT);

  state_t           state, next_state;
  logic [SEL_W-1:0] dst;
  logic             out_valid;
  logic [SEL_W-1:0] out_dst;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  logic             dst_ready;
  logic             accept;
  logic             drain;
  logic             sel_ok;
  logic             load;
  logic [SEL_W-1:0] load_dst;
  logic             drop_inc;

  // Ready of the output currently holding a beat; other outputs are ignored.
  always_comb begin
    dst_ready = 1'b0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (out_dst == SEL_W'(i)) dst_ready = m_ready[i];
    end
  end

  always_comb begin
    m_valid = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (out_dst == SEL_W'(i)) m_valid[i] = out_valid;
    end
  end

  assign m_data  = out_data;
  assign m_last  = out_last;
  assign s_ready = (state == DROP) ? 1'b1 : (!out_valid || dst_ready);
  assign accept  = s_valid && s_ready;
  assign drain   = out_valid && dst_ready;
  assign sel_ok  = {1'b0, s_sel} < N_OUT_L;

  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_dst   = dst;
    drop_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (sel_ok) begin
            load     = 1'b1;
            load_dst = s_sel;
            if (!s_last) next_state = PKT;
          end else begin
            drop_inc = 1'b1;
            if (!s_last) next_state = DROP;
          end
        end
      end
      PKT: begin
        if (accept) begin
          load = 1'b1;
          if (s_last) next_state = IDLE;
        end
      end
      DROP: begin
        if (accept && s_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dst        <= '0;
      out_valid  <= 1'b0;
      out_dst    <= '0;
      out_data   <= '0;
      out_last   <= 1'b0;
      drop_count <= '0;
    end else begin
      state <= next_state;
      // A load takes priority over a simultaneous drain: the new beat
      // replaces the departing one for full throughput.
      if (load) begin
        out_valid <= 1'b1;
        out_dst   <= load_dst;
        out_data  <= s_data;
        out_last  <= s_last;
        dst       <= load_dst;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (drop_inc && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: drives one stimulus stream into two instances
// (4 outputs / 16-bit counter, and 3 outputs / 2-bit counter) and compares
// both against a packet-level reference model.
module tb_stream_demux;

  logic       clk;
  logic       rst;
  logic [7:0] s_data;
  logic [1:0] s_sel;
  logic       s_last;
  logic       s_valid;
  logic [3:0] m_ready;

  logic        s_ready0, m_last0;
  logic [7:0]  m_data0;
  logic [3:0]  m_valid0;
  logic [15:0] drop0;
  logic        s_ready1, m_last1;
  logic [7:0]  m_data1;
  logic [2:0]  m_valid1;
  logic [1:0]  drop1;

  stream_demux #(.WIDTH(8), .N_OUT(4), .SEL_W(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_sel(s_sel), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready0), .m_data(m_data0), .m_last(m_last0),
    .m_valid(m_valid0), .m_ready(m_ready), .drop_count(drop0)
  );

  stream_demux #(.WIDTH(8), .N_OUT(3), .SEL_W(2), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_sel(s_sel), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready1), .m_data(m_data1), .m_last(m_last1),
    .m_valid(m_valid1), .m_ready(m_ready[2:0]), .drop_count(drop1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model per instance: packet open flag, destination of the open
  // packet (-1 while discarding), the beat waiting at the outputs, drops.
  int         nout[2] = '{4, 3};
  int         cmax[2] = '{65535, 3};
  bit         open_pkt[2];
  int         pdst[2];
  bit         hv[2];
  int         hdst[2];
  logic [7:0] hdata[2];
  bit         hlast[2];
  int         dc[2];

  task automatic cycle(input bit r, input bit v, input int sel, input logic [7:0] d,
                       input bit l, input logic [3:0] rdy, output bit acc0);
    logic [1:0] srdy;
    logic [3:0] mv   [2];
    logic [7:0] md   [2];
    logic       ml   [2];
    int         dcnt [2];
    rst = r; s_valid = v; s_sel = sel[1:0]; s_data = d; s_last = l; m_ready = rdy;
    #1;
    srdy = {s_ready1, s_ready0};
    acc0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bit er, acc, drn;
      if (r) begin
        open_pkt[k] = 0; pdst[k] = 0; hv[k] = 0; hdst[k] = 0;
        hdata[k] = 8'h00; hlast[k] = 0; dc[k] = 0;
      end else begin
        er = (open_pkt[k] && pdst[k] < 0) || !hv[k] || rdy[hdst[k]];
        check($sformatf("s_ready%0d", k), {31'd0, srdy[k]}, {31'd0, er});
        acc = v && er;
        drn = hv[k] && rdy[hdst[k]];
        if (k == 0) acc0 = acc;
        if (drn) hv[k] = 0;
        if (acc) begin
          if (!open_pkt[k]) begin
            if (sel < nout[k]) pdst[k] = sel;
            else begin
              pdst[k] = -1;
              if (dc[k] < cmax[k]) dc[k]++;
            end
            open_pkt[k] = !l;
          end else if (l) begin
            open_pkt[k] = 0;
          end
          if (pdst[k] >= 0) begin
            hv[k] = 1; hdst[k] = pdst[k]; hdata[k] = d; hlast[k] = l;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    mv[0] = m_valid0;         mv[1] = {1'b0, m_valid1};
    md[0] = m_data0;          md[1] = m_data1;
    ml[0] = m_last0;          ml[1] = m_last1;
    dcnt[0] = int'(drop0);    dcnt[1] = int'(drop1);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("m_valid%0d", k), {28'd0, mv[k]}, hv[k] ? (32'd1 << hdst[k]) : 32'd0);
      check($sformatf("m_data%0d", k), {24'd0, md[k]}, {24'd0, hdata[k]});
      check($sformatf("m_last%0d", k), {31'd0, ml[k]}, {31'd0, hlast[k]});
      check($sformatf("drop_count%0d", k), dcnt[k], dc[k]);
    end
  endtask

  // Offer one beat until instance 0 accepts it (bounded).
  task automatic send(input int sel, input logic [7:0] d, input bit l, input logic [3:0] rdy);
    bit a;
    a = 1'b0;
    for (int n = 0; n < 16 && !a; n++) cycle(1'b0, 1'b1, sel, d, l, rdy, a);
    if (!a) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 8'h00, 1'b0, 4'hF, a);
  endtask

  initial begin
    bit a;
    rst = 1'b1; s_valid = 1'b0; s_sel = '0; s_data = '0; s_last = 1'b0; m_ready = '0;
    cycle(1'b1, 1'b0, 0, 8'h00, 1'b0, 4'hF, a);
    cycle(1'b1, 1'b0, 0, 8'h00, 1'b0, 4'hF, a);

    // 3-beat packet to output 2 at full rate
    send(2, 8'h11, 1'b0, 4'hF);
    send(2, 8'h22, 1'b0, 4'hF);
    send(2, 8'h33, 1'b1, 4'hF);
    idle(1);

    // select changes mid-packet are ignored; next packet uses new select
    send(1, 8'hA1, 1'b0, 4'hF);
    send(0, 8'hA2, 1'b0, 4'hF);
    send(0, 8'hA3, 1'b1, 4'hF);
    send(0, 8'hB1, 1'b0, 4'hF);
    send(0, 8'hB2, 1'b1, 4'hF);
    idle(1);

    // back-pressure from output 3 for 4 cycles; output 0 ready low too
    send(3, 8'hC1, 1'b0, 4'hF);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 3, 8'hC2, 1'b0, 4'b0110, a);
    send(3, 8'hC2, 1'b0, 4'hF);
    send(3, 8'hC3, 1'b1, 4'hF);
    idle(1);

    // 2-beat packet to select 3, then a packet to output 0
    send(3, 8'hD1, 1'b0, 4'hF);
    send(3, 8'hD2, 1'b1, 4'hF);
    send(0, 8'hD3, 1'b1, 4'hF);
    idle(1);

    // single-beat packets to select 3: saturates the 2-bit counter
    for (int i = 0; i < 5; i++) send(3, 8'hE0 + 8'(i), 1'b1, 4'hF);
    idle(1);

    // reset while a beat is held mid-packet
    send(2, 8'h5A, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 0, 8'h00, 1'b0, 4'h0, a);
    send(1, 8'h77, 1'b1, 4'hF);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(0, 299) == 0);
      cycle(r, $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), 8'($urandom),
            $urandom_range(0, 2) == 0,
            {$urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
             $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7}, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
